// File: rtl/header_parser_pkg.sv
// header_parser_pkg: shared constants, emitter states, descriptor type and
// byte-extraction helpers for the header_parser block.
// The 802.1Q offsets are used only when HEADER_PARSER_VLAN_EN is defined.
package header_parser_pkg;

  localparam int TAP_WIDTH = 256;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
  localparam logic [7:0]  PROTO_TCP      = 8'd6;
  localparam logic [7:0]  PROTO_UDP      = 8'd17;

  // Untagged offsets: beat 0 positions are wire bytes, beat 1 positions are
  // relative to the start of the second beat (wire byte 32).
  localparam int OFF_ETYPE        = 12;
  localparam int OFF_VER_IHL      = 14;
  localparam int OFF_PROTO        = 23;
  localparam int OFF_SRC_IP       = 26;
  localparam int OFF_DST_IP_HI    = 30;
  localparam int B1_DST_IP_LO     = 0;
  localparam int B1_SRC_PORT      = 2;
  localparam int B1_DST_PORT      = 4;

  // 802.1Q tagged offsets: everything after the tag moves by 4 bytes.
  localparam int OFF_INNER_ETYPE    = 16;
  localparam int OFF_VER_IHL_VLAN   = 18;
  localparam int OFF_PROTO_VLAN     = 27;
  localparam int OFF_SRC_IP_HI_VLAN = 30;
  localparam int B1_SRC_IP_LO_VLAN  = 0;
  localparam int B1_DST_IP_VLAN     = 2;
  localparam int B1_SRC_PORT_VLAN   = 6;
  localparam int B1_DST_PORT_VLAN   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LOOK = 2'd2,
    ST_CLR  = 2'd3
  } emit_state_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic        l4_valid;
  } hdr_desc_t;

  function automatic logic [7:0] beat_byte(input logic [TAP_WIDTH-1:0] beat, input int n);
    return beat[8*n +: 8];
  endfunction

  // Multi-byte fields are big-endian on the wire: lowest byte index is MSB.
  function automatic logic [15:0] beat_u16(input logic [TAP_WIDTH-1:0] beat, input int n);
    return {beat_byte(beat, n), beat_byte(beat, n + 1)};
  endfunction

  function automatic logic [31:0] beat_u32(input logic [TAP_WIDTH-1:0] beat, input int n);
    return {beat_u16(beat, n), beat_u16(beat, n + 2)};
  endfunction

  // Combine the beat-0 summary with the (optional) second beat into the
  // descriptor, applying the zeroing rules for non-IPv4, non-L4 and short
  // packets.
  function automatic hdr_desc_t assemble_desc(
    input logic                 is_ip,
    input logic                 is_vlan,
    input logic                 l4_ok,
    input logic [31:0]          w0,
    input logic [15:0]          w1,
    input logic                 have_b1,
    input logic [TAP_WIDTH-1:0] b1
  );
    hdr_desc_t d;
    d = '0;
    if (is_ip) begin
      if (is_vlan) begin
        d.src_ip = {w0[31:16], (have_b1 ? beat_u16(b1, B1_SRC_IP_LO_VLAN) : 16'h0000)};
      end else begin
        d.src_ip = w0;
      end
      if (have_b1) begin
        d.dst_ip = is_vlan ? beat_u32(b1, B1_DST_IP_VLAN) : {w1, beat_u16(b1, B1_DST_IP_LO)};
        if (l4_ok) begin
          d.l4_valid = 1'b1;
          d.src_port = is_vlan ? beat_u16(b1, B1_SRC_PORT_VLAN) : beat_u16(b1, B1_SRC_PORT);
          d.dst_port = is_vlan ? beat_u16(b1, B1_DST_PORT_VLAN) : beat_u16(b1, B1_DST_PORT);
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/header_parser_fifo.sv
// hdr_desc_fifo: synchronous descriptor FIFO, DEPTH entries (power of 2, >= 2).
// A push while full is accepted only if a pop happens in the same cycle.
// full_o is registered from the post-update occupancy.
module hdr_desc_fifo
  import header_parser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  hdr_desc_t data_i,
  input  logic      pop_i,
  output hdr_desc_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  hdr_desc_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic            full_q;
  logic            wr_en;
  logic            rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_q || rd_en);
  assign data_o  = mem_q[rd_ptr_q];

  // Next occupancy from this cycle's accepted push/pop.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap explicitly at DEPTH-1; occupancy and full flag registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/header_parser.sv
// header_parser: passive AXI4-Stream tap that extracts IPv4 5-tuple fields,
// queues one descriptor per packet and presents it to the filter with an
// hdr_rd / hdr_clear pulse pair.
// Optional: define HEADER_PARSER_VLAN_EN to parse 802.1Q-tagged frames.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for a queued descriptor; loads head into outputs
//  ST_RD   | hdr_rd high, fields valid
//  ST_LOOK | filter performing lookup, fields held
//  ST_CLR  | hdr_clear high, FIFO head popped
module header_parser
  import header_parser_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int HDR_FIFO_DEPTH       = 4
) (
  input  logic                              axi_aclk,
  input  logic                              axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic                              hdr_rd,
  output logic                              hdr_clear,
  output logic [31:0]                       hdr_src_ip,
  output logic [31:0]                       hdr_dst_ip,
  output logic [15:0]                       hdr_src_port,
  output logic [15:0]                       hdr_dst_port,
  output logic                              hdr_l4_valid,
  output logic                              hdr_fifo_full,
  output logic [31:0]                       drop_count
);

  logic [TAP_WIDTH-1:0] tap_data;
  logic                 accept;
  logic                 unused_ok;

  assign tap_data  = s_axis_tdata;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign unused_ok = ^{s_axis_tkeep, s_axis_tuser};

  // ---------------------------------------------------------------------
  // Beat-0 summary of the current beat (only meaningful when beat_q == 0)
  // ---------------------------------------------------------------------
  logic [15:0] etype_outer;
  logic [15:0] etype_sel;
  logic [7:0]  ver_ihl_sel;
  logic [7:0]  proto_sel;
  logic        b0_vlan;
  logic        b0_ip;
  logic        b0_l4ok;
  logic [31:0] b0_w0;
  logic [15:0] b0_w1;

  // Classify the first beat: select tagged/untagged offsets and summarise.
  always_comb begin
    etype_outer = beat_u16(tap_data, OFF_ETYPE);
    etype_sel   = etype_outer;
    ver_ihl_sel = beat_byte(tap_data, OFF_VER_IHL);
    proto_sel   = beat_byte(tap_data, OFF_PROTO);
    b0_vlan     = 1'b0;
`ifdef HEADER_PARSER_VLAN_EN
    if (etype_outer == ETHERTYPE_VLAN) begin
      b0_vlan     = 1'b1;
      etype_sel   = beat_u16(tap_data, OFF_INNER_ETYPE);
      ver_ihl_sel = beat_byte(tap_data, OFF_VER_IHL_VLAN);
      proto_sel   = beat_byte(tap_data, OFF_PROTO_VLAN);
    end
`endif
    b0_ip   = (etype_sel == ETHERTYPE_IPV4) && (ver_ihl_sel[7:4] == 4'd4);
    b0_l4ok = (ver_ihl_sel[3:0] == 4'd5) && ((proto_sel == PROTO_TCP) || (proto_sel == PROTO_UDP));
    b0_w0   = b0_vlan ? {beat_u16(tap_data, OFF_SRC_IP_HI_VLAN), 16'h0000}
                      : beat_u32(tap_data, OFF_SRC_IP);
    b0_w1   = b0_vlan ? 16'h0000 : beat_u16(tap_data, OFF_DST_IP_HI);
  end

  // ---------------------------------------------------------------------
  // Beat counter and captured header state
  // ---------------------------------------------------------------------
  logic [1:0]  beat_q;
  logic        b0_ip_q;
  logic        b0_vlan_q;
  logic        b0_l4ok_q;
  logic [31:0] b0_w0_q;
  logic [15:0] b0_w1_q;
  logic [79:0] b1_q;

  // Count accepted beats (0, 1, 2 saturating) and capture beats 0 and 1.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      beat_q    <= 2'd0;
      b0_ip_q   <= 1'b0;
      b0_vlan_q <= 1'b0;
      b0_l4ok_q <= 1'b0;
      b0_w0_q   <= '0;
      b0_w1_q   <= '0;
      b1_q      <= '0;
    end else if (accept) begin
      if (beat_q == 2'd0) begin
        b0_ip_q   <= b0_ip;
        b0_vlan_q <= b0_vlan;
        b0_l4ok_q <= b0_l4ok;
        b0_w0_q   <= b0_w0;
        b0_w1_q   <= b0_w1;
      end
      if (beat_q == 2'd1) b1_q <= tap_data[79:0];
      if (s_axis_tlast)          beat_q <= 2'd0;
      else if (beat_q != 2'd2)   beat_q <= beat_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Descriptor assembly: on the tlast beat, merge captured state with the
  // live beat so the FIFO holds the descriptor one cycle after tlast.
  // ---------------------------------------------------------------------
  logic                 first_beat;
  logic [TAP_WIDTH-1:0] b1_beat;
  hdr_desc_t            push_desc;
  logic                 push;
  logic                 pop;
  hdr_desc_t            head_desc;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign first_beat = (beat_q == 2'd0);
  assign b1_beat    = (beat_q == 2'd1) ? tap_data : {{(TAP_WIDTH-80){1'b0}}, b1_q};
  assign push       = accept && s_axis_tlast;

  // Build the descriptor from either the live beat or the captured state.
  always_comb begin
    push_desc = assemble_desc(first_beat ? b0_ip   : b0_ip_q,
                              first_beat ? b0_vlan : b0_vlan_q,
                              first_beat ? b0_l4ok : b0_l4ok_q,
                              first_beat ? b0_w0   : b0_w0_q,
                              first_beat ? b0_w1   : b0_w1_q,
                              !first_beat,
                              b1_beat);
  end

  hdr_desc_fifo #(
    .DEPTH (HDR_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (axi_aclk),
    .rst_i   (axi_areset),
    .push_i  (push),
    .data_i  (push_desc),
    .pop_i   (pop),
    .data_o  (head_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign hdr_fifo_full = fifo_full;

  // ---------------------------------------------------------------------
  // Overflow accounting
  // ---------------------------------------------------------------------
  logic [31:0] drop_count_q;
  logic        drop;

  assign drop       = push && fifo_full && !pop;
  assign drop_count = drop_count_q;

  // Count discarded descriptors, saturating at all-ones.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      drop_count_q <= '0;
    end else if (drop && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_q <= drop_count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Emitter FSM
  // ---------------------------------------------------------------------
  emit_state_t state_q;
  logic        hdr_rd_q;
  logic        hdr_clear_q;
  hdr_desc_t   out_q;

  assign pop = (state_q == ST_CLR);

  // Present each descriptor as rd -> (lookup) -> clear; fields load only on IDLE->RD.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q     <= ST_IDLE;
      hdr_rd_q    <= 1'b0;
      hdr_clear_q <= 1'b0;
      out_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hdr_clear_q <= 1'b0;
          if (!fifo_empty) begin
            out_q    <= head_desc;
            hdr_rd_q <= 1'b1;
            state_q  <= ST_RD;
          end
        end
        ST_RD: begin
          hdr_rd_q <= 1'b0;
          state_q  <= ST_LOOK;
        end
        ST_LOOK: begin
          hdr_clear_q <= 1'b1;
          state_q     <= ST_CLR;
        end
        ST_CLR: begin
          hdr_clear_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hdr_rd       = hdr_rd_q;
  assign hdr_clear    = hdr_clear_q;
  assign hdr_src_ip   = out_q.src_ip;
  assign hdr_dst_ip   = out_q.dst_ip;
  assign hdr_src_port = out_q.src_port;
  assign hdr_dst_port = out_q.dst_port;
  assign hdr_l4_valid = out_q.l4_valid;

endmodule

// File: tb/tb_header_parser.sv
// tb_header_parser: directed bench for header_parser (default depth 4).
// Expectations follow HEADER_PARSER_VLAN_EN when the bench is built with it.
module tb_header_parser;

  logic         clk;
  logic         rst;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         hdr_rd;
  logic         hdr_clear;
  logic [31:0]  hdr_src_ip;
  logic [31:0]  hdr_dst_ip;
  logic [15:0]  hdr_src_port;
  logic [15:0]  hdr_dst_port;
  logic         hdr_l4_valid;
  logic         hdr_fifo_full;
  logic [31:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  header_parser dut (
    .axi_aclk      (clk),
    .axi_areset    (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tuser  (tuser),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .hdr_rd        (hdr_rd),
    .hdr_clear     (hdr_clear),
    .hdr_src_ip    (hdr_src_ip),
    .hdr_dst_ip    (hdr_dst_ip),
    .hdr_src_port  (hdr_src_port),
    .hdr_dst_port  (hdr_dst_port),
    .hdr_l4_valid  (hdr_l4_valid),
    .hdr_fifo_full (hdr_fifo_full),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Untagged beat 0: ethertype, ver/IHL, proto, src IP, dst IP high half.
  function automatic logic [255:0] ip_b0(input logic [15:0] et, input logic [7:0] vihl,
                                         input logic [7:0] proto, input logic [31:0] src,
                                         input logic [15:0] dhi);
    logic [255:0] d;
    d = {32{8'hA5}};
    d[12*8 +: 8] = et[15:8];   d[13*8 +: 8] = et[7:0];
    d[14*8 +: 8] = vihl;       d[23*8 +: 8] = proto;
    d[26*8 +: 8] = src[31:24]; d[27*8 +: 8] = src[23:16];
    d[28*8 +: 8] = src[15:8];  d[29*8 +: 8] = src[7:0];
    d[30*8 +: 8] = dhi[15:8];  d[31*8 +: 8] = dhi[7:0];
    return d;
  endfunction

  // Untagged beat 1: dst IP low half, src port, dst port.
  function automatic logic [255:0] ip_b1(input logic [15:0] dlo, input logic [15:0] sp,
                                         input logic [15:0] dp);
    logic [255:0] d;
    d = {32{8'h3C}};
    d[0*8 +: 8] = dlo[15:8]; d[1*8 +: 8] = dlo[7:0];
    d[2*8 +: 8] = sp[15:8];  d[3*8 +: 8] = sp[7:0];
    d[4*8 +: 8] = dp[15:8];  d[5*8 +: 8] = dp[7:0];
    return d;
  endfunction

  // 802.1Q beat 0: TPID, inner ethertype, ver/IHL, proto, src IP high half.
  function automatic logic [255:0] vlan_b0(input logic [15:0] et, input logic [7:0] vihl,
                                           input logic [7:0] proto, input logic [15:0] shi);
    logic [255:0] d;
    d = {32{8'hA5}};
    d[12*8 +: 8] = 8'h81;     d[13*8 +: 8] = 8'h00;
    d[16*8 +: 8] = et[15:8];  d[17*8 +: 8] = et[7:0];
    d[18*8 +: 8] = vihl;      d[27*8 +: 8] = proto;
    d[30*8 +: 8] = shi[15:8]; d[31*8 +: 8] = shi[7:0];
    return d;
  endfunction

  // 802.1Q beat 1: src IP low half, dst IP, src port, dst port.
  function automatic logic [255:0] vlan_b1(input logic [15:0] slo, input logic [31:0] dst,
                                           input logic [15:0] sp, input logic [15:0] dp);
    logic [255:0] d;
    d = {32{8'h3C}};
    d[0*8 +: 8] = slo[15:8];  d[1*8 +: 8] = slo[7:0];
    d[2*8 +: 8] = dst[31:24]; d[3*8 +: 8] = dst[23:16];
    d[4*8 +: 8] = dst[15:8];  d[5*8 +: 8] = dst[7:0];
    d[6*8 +: 8] = sp[15:8];   d[7*8 +: 8] = sp[7:0];
    d[8*8 +: 8] = dp[15:8];   d[9*8 +: 8] = dp[7:0];
    return d;
  endfunction

  task automatic beat(input logic [255:0] d, input logic last);
    tdata = d; tlast = last; tvalid = 1'b1; tready = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // Called in cycle T+1 after the tlast beat at T; consumes through T+5.
  task automatic expect_desc(input string tag, input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] sp, input logic [15:0] dp, input logic l4);
    chk({tag, ".rd_t1"}, 32'(hdr_rd), 32'd0);
    tick();
    chk({tag, ".rd_t2"},    32'(hdr_rd), 32'd1);
    chk({tag, ".clr_t2"},   32'(hdr_clear), 32'd0);
    chk({tag, ".src_ip"},   hdr_src_ip, s);
    chk({tag, ".dst_ip"},   hdr_dst_ip, d);
    chk({tag, ".src_port"}, 32'(hdr_src_port), 32'(sp));
    chk({tag, ".dst_port"}, 32'(hdr_dst_port), 32'(dp));
    chk({tag, ".l4_valid"}, 32'(hdr_l4_valid), 32'(l4));
    tick();
    chk({tag, ".rd_t3"},    32'(hdr_rd), 32'd0);
    chk({tag, ".clr_t3"},   32'(hdr_clear), 32'd0);
    chk({tag, ".src_t3"},   hdr_src_ip, s);
    tick();
    chk({tag, ".clr_t4"},   32'(hdr_clear), 32'd1);
    chk({tag, ".dst_t4"},   hdr_dst_ip, d);
    chk({tag, ".dport_t4"}, 32'(hdr_dst_port), 32'(dp));
    tick();
    chk({tag, ".clr_t5"},   32'(hdr_clear), 32'd0);
  endtask

  int          rd_cyc [5];
  logic [31:0] rd_src [5];
  logic        full_at [32];
  int          nrd;
  int          nclr;
  int          last_rd;

  initial begin
    rst = 1'b1; tdata = '0; tkeep = '1; tuser = '0;
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset state
    chk("rst.rd",    32'(hdr_rd), 32'd0);
    chk("rst.clr",   32'(hdr_clear), 32'd0);
    chk("rst.src",   hdr_src_ip, 32'd0);
    chk("rst.dst",   hdr_dst_ip, 32'd0);
    chk("rst.ports", {hdr_src_port, hdr_dst_port}, 32'd0);
    chk("rst.l4",    32'(hdr_l4_valid), 32'd0);
    chk("rst.full",  32'(hdr_fifo_full), 32'd0);
    chk("rst.drop",  drop_count, 32'd0);

    // Untagged TCP 10.0.0.1:1234 -> 10.0.0.2:80, with a non-accepted stall beat
    beat(ip_b0(16'h0800, 8'h45, 8'h06, 32'h0A000001, 16'h0A00), 1'b0);
    tdata = ip_b1(16'hFFFF, 16'hFFFF, 16'hFFFF); tvalid = 1'b1; tready = 1'b0; tlast = 1'b1;
    tick();
    chk("stall.no_rd", 32'(hdr_rd), 32'd0);
    beat(ip_b1(16'h0002, 16'h04D2, 16'h0050), 1'b0);
    beat({32{8'hC3}}, 1'b1);
    expect_desc("tcp", 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 1'b1);

    // ARP ethertype: all zero even though IP-looking bytes are present
    beat(ip_b0(16'h0806, 8'h45, 8'h06, 32'h0A000001, 16'h0A00), 1'b0);
    beat(ip_b1(16'h0002, 16'h04D2, 16'h0050), 1'b1);
    expect_desc("arp", 32'd0, 32'd0, 16'd0, 16'd0, 1'b0);

    // IPv4 ethertype with version 6 is not IPv4
    beat(ip_b0(16'h0800, 8'h65, 8'h06, 32'h0A000001, 16'h0A00), 1'b0);
    beat(ip_b1(16'h0002, 16'h04D2, 16'h0050), 1'b1);
    expect_desc("ver6", 32'd0, 32'd0, 16'd0, 16'd0, 1'b0);

    // IHL=6 TCP: IPs kept, ports zero
    beat(ip_b0(16'h0800, 8'h46, 8'h06, 32'hAC100005, 16'hAC10), 1'b0);
    beat(ip_b1(16'h0006, 16'h1111, 16'h2222), 1'b1);
    expect_desc("ihl6", 32'hAC100005, 32'hAC100006, 16'd0, 16'd0, 1'b0);

    // ICMP: IPs kept, ports zero
    beat(ip_b0(16'h0800, 8'h45, 8'h01, 32'h01020304, 16'h0506), 1'b0);
    beat(ip_b1(16'h0708, 16'h3333, 16'h4444), 1'b1);
    expect_desc("icmp", 32'h01020304, 32'h05060708, 16'd0, 16'd0, 1'b0);

    // Two-beat UDP 192.168.0.1:53 -> 8.8.8.8:5353
    beat(ip_b0(16'h0800, 8'h45, 8'h11, 32'hC0A80001, 16'h0808), 1'b0);
    beat(ip_b1(16'h0808, 16'h0035, 16'h14E9), 1'b1);
    expect_desc("udp", 32'hC0A80001, 32'h08080808, 16'h0035, 16'h14E9, 1'b1);

    // Short packet (tlast on beat 0): src kept, rest zero
    beat(ip_b0(16'h0800, 8'h45, 8'h06, 32'h0A0A0A0A, 16'h0B0B), 1'b1);
    expect_desc("short", 32'h0A0A0A0A, 32'd0, 16'd0, 16'd0, 1'b0);

    // 802.1Q UDP 192.168.1.1:53 -> 192.168.1.9:5000
    beat(vlan_b0(16'h0800, 8'h45, 8'h11, 16'hC0A8), 1'b0);
    beat(vlan_b1(16'h0101, 32'hC0A80109, 16'h0035, 16'h1388), 1'b1);
`ifdef HEADER_PARSER_VLAN_EN
    expect_desc("vlan", 32'hC0A80101, 32'hC0A80109, 16'h0035, 16'h1388, 1'b1);
`else
    expect_desc("vlan", 32'd0, 32'd0, 16'd0, 16'd0, 1'b0);
`endif
    chk("pre_ovf.drop", drop_count, 32'd0);
    chk("pre_ovf.full", 32'(hdr_fifo_full), 32'd0);

    // Overflow: 6 back-to-back 1-beat packets; sample k is cycle k
    nrd = 0; nclr = 0; last_rd = -100;
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin
        tdata = ip_b0(16'h0800, 8'h45, 8'h06, 32'h0B000001 + i, 16'h0000);
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
      end else begin
        tvalid = 1'b0; tlast = 1'b0;
      end
      tick();
      full_at[i + 1] = hdr_fifo_full;
      if (hdr_rd) begin
        if (nrd < 5) begin
          rd_cyc[nrd] = i + 1;
          rd_src[nrd] = hdr_src_ip;
        end
        nrd++;
        last_rd = i + 1;
      end
      if (hdr_clear) begin
        nclr++;
        chk("ovf.rd_to_clr", 32'(i + 1 - last_rd), 32'd2);
      end
    end
    chk("ovf.n_rd",  32'(nrd), 32'd5);
    chk("ovf.n_clr", 32'(nclr), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ovf.rd_cyc%0d", k), 32'(rd_cyc[k]), 32'(2 + 4 * k));
      chk($sformatf("ovf.rd_src%0d", k), rd_src[k], 32'h0B000001 + 32'(k));
    end
    chk("ovf.full_c3", 32'(full_at[3]), 32'd0);
    chk("ovf.full_c4", 32'(full_at[4]), 32'd1);
    chk("ovf.full_c8", 32'(full_at[8]), 32'd1);
    chk("ovf.full_c9", 32'(full_at[9]), 32'd0);
    chk("ovf.drop",    drop_count, 32'd1);

    // Reset mid-packet with one descriptor queued and hdr_rd active
    beat(ip_b0(16'h0800, 8'h45, 8'h06, 32'h0C000001, 16'h0000), 1'b1);
    beat(ip_b0(16'h0800, 8'h45, 8'h06, 32'hDEADBEEF, 16'hDEAD), 1'b0);
    chk("mid.rd_before",  32'(hdr_rd), 32'd1);
    chk("mid.src_before", hdr_src_ip, 32'h0C000001);
    rst = 1'b1;
    #1;
    chk("mid.rd_async",   32'(hdr_rd), 32'd0);
    chk("mid.src_async",  hdr_src_ip, 32'd0);
    chk("mid.drop_async", drop_count, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hdr_rd) nrd++;
    end
    chk("mid.no_rd", 32'(nrd), 32'd0);
    chk("mid.full",  32'(hdr_fifo_full), 32'd0);

    // Clean packet after reset parses from beat 0
    beat(ip_b0(16'h0800, 8'h45, 8'h06, 32'h0A000003, 16'h0A00), 1'b0);
    beat(ip_b1(16'h0004, 16'h10E1, 16'h01BB), 1'b0);
    beat({32{8'hC3}}, 1'b1);
    expect_desc("post_rst", 32'h0A000003, 32'h0A000004, 16'h10E1, 16'h01BB, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
